// File: rtl/draw_game_pkg.sv
// Shared types and constants for the game-scene overlay pipeline.
package draw_game_pkg;

  typedef enum logic {RUN = 1'b0, HIT = 1'b1} game_state_t;

  typedef logic [10:0] coord_t;

  localparam logic [11:0] COLOR_BIRD_DEF = 12'h00F;
  localparam logic [11:0] COLOR_TUBE_DEF = 12'hF00;

  // Video beat carried down the pipeline: coordinates, sync/blank, pixel.
  typedef struct packed {
    coord_t      h;
    coord_t      v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vid_t;

  // Widen a coordinate so edge sums cannot wrap.
  function automatic logic [11:0] ext12(coord_t c);
    return {1'b0, c};
  endfunction

endpackage

// File: rtl/draw_game_pipe_if.sv
// Video in/out stream plus game-object inputs and game-state outputs.
interface draw_game_pipe_if
  import draw_game_pkg::*;
#(
  parameter int N_TUBES = 3
);
  logic                   game_rst;
  coord_t                 hcount_in, vcount_in;
  logic                   hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0]            rgb_in;
  coord_t                 bird_y;
  logic [N_TUBES*11-1:0]  tube_x;
  logic [N_TUBES*11-1:0]  gap_y;
  coord_t                 hcount_out, vcount_out;
  logic                   hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0]            rgb_out;
  logic                   collision;
  logic [7:0]             score;

  modport master (
    output game_rst, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, bird_y, tube_x, gap_y,
    input  hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, collision, score
  );

  modport slave (
    input  game_rst, hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
           rgb_in, bird_y, tube_x, gap_y,
    output hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
           rgb_out, collision, score
  );
endinterface

// File: rtl/tube_hit_unit.sv
// Combinational per-tube coverage test: pixel lies in a tube column band
// but outside the gap. Tubes parked at or beyond H_ACTIVE are never drawn.
module tube_hit_unit
  import draw_game_pkg::*;
#(
  parameter int TUBE_W   = 60,
  parameter int GAP_H    = 200,
  parameter int H_ACTIVE = 1024
) (
  input  coord_t h,
  input  coord_t v,
  input  coord_t tx,
  input  coord_t gy,
  output logic   hit
);
  logic [11:0] tx_end, gy_end;

  assign tx_end = ext12(tx) + 12'(TUBE_W);
  assign gy_end = ext12(gy) + 12'(GAP_H);

  assign hit = (ext12(tx) < 12'(H_ACTIVE)) &&
               (h >= tx) && (ext12(h) < tx_end) &&
               ((v < gy) || (ext12(v) >= gy_end));
endmodule

// File: rtl/draw_game_pipe.sv
// Two-stage tube/bird overlay with per-frame snapshots, collision FSM
// and saturating score counter.
module draw_game_pipe
  import draw_game_pkg::*;
#(
  parameter int          N_TUBES    = 3,
  parameter int          TUBE_W     = 60,
  parameter int          GAP_H      = 200,
  parameter int          BIRD_X     = 400,
  parameter int          BIRD_W     = 40,
  parameter int          BIRD_H     = 50,
  parameter int          H_ACTIVE   = 1024,
  parameter int          V_ACTIVE   = 768,
  parameter logic [11:0] COLOR_BIRD = COLOR_BIRD_DEF,
  parameter logic [11:0] COLOR_TUBE = COLOR_TUBE_DEF
) (
  input logic              clk,
  input logic              rst,
  draw_game_pipe_if.slave  vif
);
  localparam logic [11:0] BX_L   = 12'(BIRD_X);
  localparam logic [11:0] BX_R   = 12'(BIRD_X + BIRD_W);
  localparam logic [11:0] BH_L   = 12'(BIRD_H);
  localparam logic [11:0] TW_L   = 12'(TUBE_W);
  localparam logic [11:0] HA_L   = 12'(H_ACTIVE);
  localparam logic [11:0] VA_L   = 12'(V_ACTIVE);

  logic                          vblnk_d, tick, blank;
  coord_t                        snap_by;
  logic [N_TUBES-1:0][10:0]      snap_tx, snap_gy;
  logic [N_TUBES-1:0]            th_vec;
  logic                          bh_c, th_c;
  vid_t                          vin, s1_vid, s2_vid;
  logic                          s1_bh, s1_th;
  game_state_t                   state_q, state_d;
  logic [7:0]                    score_q, score_d, pass_cnt;
  logic [8:0]                    score_sum;
  logic                          acc_q, acc_d;

  assign tick  = vif.vblnk_in & ~vblnk_d;
  assign blank = vif.hblnk_in | vif.vblnk_in;
  assign vin   = '{h: vif.hcount_in, v: vif.vcount_in, hs: vif.hsync_in, vs: vif.vsync_in,
                   hb: vif.hblnk_in, vb: vif.vblnk_in, rgb: vif.rgb_in};

  genvar gi;
  generate
    for (gi = 0; gi < N_TUBES; gi++) begin : g_tube
      tube_hit_unit #(.TUBE_W(TUBE_W), .GAP_H(GAP_H), .H_ACTIVE(H_ACTIVE)) u_hit (
        .h(vif.hcount_in), .v(vif.vcount_in), .tx(snap_tx[gi]), .gy(snap_gy[gi]),
        .hit(th_vec[gi])
      );
    end
  endgenerate

  assign bh_c = !blank &&
                (ext12(vif.hcount_in) >= BX_L) && (ext12(vif.hcount_in) < BX_R) &&
                (vif.vcount_in >= snap_by) && (ext12(vif.vcount_in) < ext12(snap_by) + BH_L);
  assign th_c = !blank && (|th_vec);

  // Frame-edge detector and per-frame object snapshots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      snap_by <= '0;
      snap_tx <= '1;
      snap_gy <= '0;
    end else begin
      vblnk_d <= vif.vblnk_in;
      if (tick) begin
        snap_by <= vif.bird_y;
        for (int i = 0; i < N_TUBES; i++) begin
          snap_tx[i] <= vif.tube_x[11*i +: 11];
          snap_gy[i] <= vif.gap_y[11*i +: 11];
        end
      end
    end
  end

  // S1 registers hit flags, S2 composes the pixel; timing rides alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vid <= '0;
      s1_bh  <= 1'b0;
      s1_th  <= 1'b0;
      s2_vid <= '0;
    end else begin
      s1_vid <= vin;
      s1_bh  <= bh_c;
      s1_th  <= th_c;
      s2_vid <= s1_vid;
      s2_vid.rgb <= s1_bh ? COLOR_BIRD : (s1_th ? COLOR_TUBE : s1_vid.rgb);
    end
  end

  // Count tubes whose right edge crossed the bird's left column this tick.
  always_comb begin
    pass_cnt = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      if ((ext12(snap_tx[i]) < HA_L) && (ext12(vif.tube_x[11*i +: 11]) < HA_L) &&
          (ext12(snap_tx[i]) + TW_L > BX_L) &&
          (ext12(vif.tube_x[11*i +: 11]) + TW_L <= BX_L))
        pass_cnt = pass_cnt + 8'd1;
    end
    score_sum = {1'b0, score_q} + {1'b0, pass_cnt};
  end

  // Game FSM next state: restart wins, else evaluate once per frame tick.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    acc_d   = acc_q | (bh_c & th_c);
    if (vif.game_rst) begin
      state_d = RUN;
      score_d = '0;
      acc_d   = 1'b0;
    end else if (tick) begin
      acc_d = 1'b0;
      if (state_q == RUN) begin
        score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
        if (acc_q || (ext12(snap_by) + BH_L > VA_L) || (snap_by == '0))
          state_d = HIT;
      end
    end
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      score_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      acc_q   <= acc_d;
    end
  end

  assign vif.hcount_out = s2_vid.h;
  assign vif.vcount_out = s2_vid.v;
  assign vif.hsync_out  = s2_vid.hs;
  assign vif.vsync_out  = s2_vid.vs;
  assign vif.hblnk_out  = s2_vid.hb;
  assign vif.vblnk_out  = s2_vid.vb;
  assign vif.rgb_out    = s2_vid.rgb;
  assign vif.collision  = (state_q == HIT);
  assign vif.score      = score_q;
endmodule

// File: tb/tb_draw_game_pipe.sv
// Directed bench for the overlay pipeline: drawing, collision, scoring.
module tb_draw_game_pipe;
  import draw_game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  draw_game_pipe_if #(.N_TUBES(3)) vif ();

  draw_game_pipe #(.N_TUBES(3)) dut (.clk(clk), .rst(rst), .vif(vif));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_tube(input int i, input int x, input int g);
    vif.tube_x[11*i +: 11] = 11'(x);
    vif.gap_y[11*i +: 11]  = 11'(g);
  endtask

  // One-cycle vblank pulse gives exactly one frame tick.
  task automatic frame(input bit grst);
    @(negedge clk);
    vif.vblnk_in = 1'b1;
    vif.game_rst = grst;
    @(negedge clk);
    vif.vblnk_in = 1'b0;
    vif.game_rst = 1'b0;
  endtask

  // Present one visible pixel; check composed colour and delayed h 2 cycles later.
  task automatic pix(input string tag, input int h, input int v,
                     input logic [11:0] rgb, input logic [11:0] exp);
    @(negedge clk);
    vif.hcount_in = 11'(h);
    vif.vcount_in = 11'(v);
    vif.rgb_in    = rgb;
    vif.hblnk_in  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check(tag, 32'(vif.rgb_out), 32'(exp));
    check({tag, "_h"}, 32'(vif.hcount_out), 32'(h));
    vif.hblnk_in = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    vif.game_rst = 1'b0;
    vif.hcount_in = 11'd5;
    vif.vcount_in = 11'd5;
    vif.hsync_in = 1'b1;
    vif.vsync_in = 1'b1;
    vif.hblnk_in = 1'b0;
    vif.vblnk_in = 1'b0;
    vif.rgb_in = 12'hABC;
    vif.bird_y = 11'd300;
    for (int i = 0; i < 3; i++) set_tube(i, 1030, 0);

    // Reset holds everything at zero.
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(vif.rgb_out), 32'h0);
    check("rst_h", 32'(vif.hcount_out), 32'h0);
    check("rst_hsync", 32'(vif.hsync_out), 32'h0);
    check("rst_coll", 32'(vif.collision), 32'h0);
    check("rst_score", 32'(vif.score), 32'h0);
    rst = 1'b0;
    vif.hblnk_in = 1'b1;

    // Passthrough with nothing on screen, then load a sane snapshot.
    pix("pass0", 10, 10, 12'h123, 12'h123);
    check("pass0_hsync", 32'(vif.hsync_out), 32'h1);
    frame(1'b1);
    check("init_coll", 32'(vif.collision), 32'h0);

    // Tube 0 at 500 with gap 300..499.
    set_tube(0, 500, 300);
    frame(1'b0);
    pix("tube_top", 520, 100, 12'h456, 12'hF00);
    pix("tube_gap", 520, 400, 12'h456, 12'h456);
    pix("tube_bot", 520, 600, 12'h456, 12'hF00);
    pix("tube_redge", 559, 10, 12'h456, 12'hF00);
    pix("tube_out", 560, 10, 12'h456, 12'h456);
    pix("bird", 410, 320, 12'h456, 12'h00F);
    check("run_coll", 32'(vif.collision), 32'h0);

    // Tube 1 crosses the bird's left column: 345 -> 335.
    set_tube(1, 345, 300);
    frame(1'b0);
    check("score_pre", 32'(vif.score), 32'h0);
    set_tube(1, 335, 300);
    frame(1'b0);
    check("score_pass", 32'(vif.score), 32'h1);

    // Bird overlaps tube 0 during a frame -> HIT on next tick.
    vif.bird_y = 11'd100;
    set_tube(0, 410, 300);
    set_tube(1, 1030, 300);
    frame(1'b0);
    pix("ovl_bird_wins", 420, 120, 12'h111, 12'h00F);
    check("ovl_pre_coll", 32'(vif.collision), 32'h0);
    frame(1'b0);
    check("ovl_coll", 32'(vif.collision), 32'h1);
    for (int f = 0; f < 5; f++) begin
      set_tube(1, (f == 0) ? 345 : 335, 300);
      frame(1'b0);
      check("hit_hold", 32'(vif.collision), 32'h1);
    end
    check("hit_score_frozen", 32'(vif.score), 32'h1);
    @(negedge clk);
    vif.game_rst = 1'b1;
    @(negedge clk);
    vif.game_rst = 1'b0;
    check("grst_coll", 32'(vif.collision), 32'h0);
    check("grst_score", 32'(vif.score), 32'h0);
    vif.bird_y = 11'd300;
    set_tube(0, 1030, 0);
    frame(1'b0);
    check("grst_run", 32'(vif.collision), 32'h0);

    // Floor: 720 + 50 > 768.
    vif.bird_y = 11'd720;
    frame(1'b0);
    check("floor_pre", 32'(vif.collision), 32'h0);
    frame(1'b0);
    check("floor_hit", 32'(vif.collision), 32'h1);
    // Ceiling, loaded by a tick that coincides with game_rst.
    vif.bird_y = 11'd0;
    frame(1'b1);
    check("ceil_grst_tick", 32'(vif.collision), 32'h0);
    frame(1'b0);
    check("ceil_hit", 32'(vif.collision), 32'h1);
    vif.bird_y = 11'd300;
    frame(1'b1);
    check("ceil_clear", 32'(vif.collision), 32'h0);

    // Three simultaneous passes per round; run into saturation.
    for (int i = 0; i < 3; i++) set_tube(i, 345, 300);
    frame(1'b0);
    for (int i = 0; i < 3; i++) set_tube(i, 335, 300);
    frame(1'b0);
    check("score_multi", 32'(vif.score), 32'd3);
    for (int r = 0; r < 83; r++) begin
      for (int i = 0; i < 3; i++) set_tube(i, 345, 300);
      frame(1'b0);
      for (int i = 0; i < 3; i++) set_tube(i, 335, 300);
      frame(1'b0);
    end
    check("score_252", 32'(vif.score), 32'd252);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) set_tube(i, 345, 300);
      frame(1'b0);
      for (int i = 0; i < 3; i++) set_tube(i, 335, 300);
      frame(1'b0);
    end
    check("score_sat", 32'(vif.score), 32'd255);
    check("sat_coll", 32'(vif.collision), 32'h0);

    // Tubes parked beyond the visible area are never drawn.
    for (int i = 0; i < 3; i++) set_tube(i, 1030, 0);
    frame(1'b0);
    pix("off_1030", 1030, 400, 12'h321, 12'h321);
    pix("off_1035", 1035, 10, 12'h321, 12'h321);
    pix("off_0", 0, 400, 12'h321, 12'h321);
    check("off_score", 32'(vif.score), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/draw_game_pipe.md
Name: draw_game_pipe

Overview:
- Parametrised, pipelined successor to the game-scene renderer.
- Overlays N_TUBES tubes and the bird onto an incoming VGA stream.
- Latches object positions once per frame so every frame is drawn from a coherent snapshot.
- Detects collisions per frame and latches them; counts tubes passed as score.
- Sits between the background stage and the VGA output register stage.

Parameters:
- N_TUBES, 3, number of tube channels
- TUBE_W, 60, tube width in pixels
- GAP_H, 200, vertical gap height in pixels
- BIRD_X, 400, bird left column
- BIRD_W, 40, bird width
- BIRD_H, 50, bird height
- H_ACTIVE, 1024, visible columns; tubes with x >= H_ACTIVE are not drawn
- V_ACTIVE, 768, visible rows
- COLOR_BIRD, 12'h00F, bird colour
- COLOR_TUBE, 12'hF00, tube colour

Ports:
- clk, in, 1, pixel clock
- rst, in, 1, asynchronous active-high reset
- game_rst, in, 1, synchronous game restart
- hcount_in, vcount_in, in, 11 each, pixel coordinates
- hsync_in, vsync_in, hblnk_in, vblnk_in, in, 1 each, timing signals
- rgb_in, in, 12, background pixel
- bird_y, in, 11, bird top row (live)
- tube_x, in, N_TUBES*11, packed tube left columns; channel i at [11*i +: 11]
- gap_y, in, N_TUBES*11, packed gap top rows
- hcount_out, vcount_out, out, 11 each, timing delayed by 2 cycles
- hsync_out, vsync_out, hblnk_out, vblnk_out, out, 1 each, timing delayed by 2 cycles
- rgb_out, out, 12, composed pixel
- collision, out, 1, high while in HIT state
- score, out, 8, tubes passed, saturating

Behaviour:
- rst (asynchronous):
  - All outputs and pipeline registers go to 0.
  - State = RUN, score = 0.
  - Snapshots: tube_x = all-ones (off screen), gap_y = 0, bird_y = 0.
- Frame tick: rising edge of vblnk_in (registered vblnk_in = 0, current = 1). One cycle wide.
- On the frame tick:
  - Copy bird_y, tube_x and gap_y into snapshot registers.
  - The previous tube_x snapshot is retained for scoring.
- Pipeline, latency exactly 2 cycles for all outputs:
  - S1 registers the bird_hit flag and the tube_hit flag (OR over channels), computed from the snapshots.
  - S2 muxes the colour: bird over tube over rgb_in (delayed).
- Arithmetic:
  - All edge sums are computed at 12 bits, so tube_x + TUBE_W and gap_y + GAP_H never wrap.
  - bird_hit: BIRD_X <= h < BIRD_X+BIRD_W and by <= v < by+BIRD_H.
  - tube_hit(i): tx < H_ACTIVE, tx <= h < tx+TUBE_W, and (v < gy or v >= gy+GAP_H).
- Hit flags are forced to 0 while hblnk_in or vblnk_in is high.
- overlap_acc:
  - Set when bird_hit and tube_hit are both true in the same S1 cycle.
  - Cleared on the frame tick after it has been evaluated.
- FSM RUN -> HIT on the frame tick if either:
  - overlap_acc = 1, or
  - snapshot bird_y + BIRD_H > V_ACTIVE (floor), or
  - snapshot bird_y = 0 (ceiling).
- HIT holds until game_rst. collision = (state == HIT), registered.
- Score, evaluated on the frame tick while in RUN:
  - For each channel, count a pass when prev_x + TUBE_W > BIRD_X and new_x + TUBE_W <= BIRD_X, with both values below H_ACTIVE.
  - Add the number of passes; saturate at 255.
  - A tube wrapping to the right edge never counts.
- In HIT the score is frozen.
- Simultaneous pass and collision on the same tick: the score is incremented, then HIT is entered.
- game_rst (synchronous, highest priority after rst):
  - State = RUN, score = 0, overlap_acc = 0.
  - Snapshots and pipeline are unaffected, so video continues.
- If game_rst coincides with a frame tick, the snapshot still updates and no collision or score evaluation occurs.

Decomposition:
- Package draw_game_pkg holds:
  - typedef enum {RUN, HIT} game_state_t
  - typedef logic [10:0] coord_t
  - colour constants
- Sub-module tube_hit_unit is instantiated N_TUBES times via generate. It is purely combinational: inputs are h, v, tx, gy; the output is the hit flag.

Test Plan:
- Reset, then any input: all outputs 0 and score 0 while rst is high; after release, rgb_out = rgb_in delayed 2 cycles with no objects on screen.
- tube_x[0]=500, gap_y[0]=300, frame tick, pixel (h=520, v=100) -> rgb_out = 12'hF00 2 cycles later; pixel (520, 400) -> rgb_in.
- bird_y=100 with tube_x[0]=410, gap_y[0]=300 -> one frame later collision=1; it stays 1 over 5 frames; game_rst -> collision=0 on the next cycle.
- tube_x[1] goes 345 -> 335 across a tick (BIRD_X=400, TUBE_W=60) -> score becomes 1; the same move while in HIT leaves the score unchanged.
- bird_y=720 (720+50 > 768) -> HIT at the next tick; bird_y=0 -> HIT.
- score at 255 with another pass -> score stays 255; tube_x=1030 -> no tube drawn in any column.
